cr16_alu: RTL and testbench



---
 rtl/cr16_alu_if.sv | 16 +
 rtl/cr16_alu.sv | 83 ++++++++
 tb/tb_cr16_alu.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cr16_alu_if.sv
// cr16_alu_if: operation request / registered result bundle for cr16_alu.
//   I_OPCODE  [3:0]  operation select          (master -> slave)
//   I_A       [15:0] source operand / shift amt (master -> slave)
//   I_B       [15:0] destination / shift value  (master -> slave)
//   O_C       [15:0] registered result          (slave -> master)
//   O_STATUS  [4:0]  {neg, zero, flag, low, carry} (slave -> master)
interface cr16_alu_if;
  logic [3:0]  I_OPCODE;
  logic [15:0] I_A;
  logic [15:0] I_B;
  logic [15:0] O_C;
  logic [4:0]  O_STATUS;

  modport master (output I_OPCODE, I_A, I_B, input  O_C, O_STATUS);
  modport slave  (input  I_OPCODE, I_A, I_B, output O_C, O_STATUS);
endinterface

// File: rtl/cr16_alu.sv
// cr16_alu: CompactRISC16 16-bit ALU with registered result and status.
//   I_CLK     rising-edge clock
//   I_NRESET  async active-low reset, clears O_C / O_STATUS
//   bus       cr16_alu_if.slave: I_OPCODE, I_A, I_B in; O_C, O_STATUS out
// Status layout: [0] carry, [1] low, [2] flag (signed ovf), [3] zero, [4] neg.
// Build option: define CR16_ALU_MUL_EN to implement MUL (opcode 2); otherwise
// opcode 2 is treated as an unused opcode (result 0, status 0).
module cr16_alu (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  cr16_alu_if.slave  bus
);
  localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADDC = 4'd1,  OP_MUL = 4'd2,
                         OP_SUB  = 4'd3,  OP_NOT  = 4'd4,  OP_AND = 4'd5,
                         OP_OR   = 4'd6,  OP_XOR  = 4'd7,  OP_LSH = 4'd8,
                         OP_RSH  = 4'd9,  OP_ALSH = 4'd10, OP_ARSH = 4'd11;

  logic [15:0] a, b, c_d, c_q;
  logic [4:0]  status_d, status_q;
  logic [16:0] sum;
  logic [15:0] diff;
  logic [3:0]  shamt;
  logic        carry, low, flag, neg, op_ok;

  assign a     = bus.I_A;
  assign b     = bus.I_B;
  assign shamt = a[3:0];

  // Single adder serves ADD and ADDC; ADDC's carry-in is fixed at 1.
  assign sum  = {1'b0, a} + {1'b0, b} + {16'd0, bus.I_OPCODE == OP_ADDC};
  assign diff = b - a;

  always_comb begin
    c_d   = '0;
    carry = 1'b0;
    low   = 1'b0;
    flag  = 1'b0;
    neg   = 1'b0;
    op_ok = 1'b1;
    unique case (bus.I_OPCODE)
      OP_ADD, OP_ADDC: begin
        c_d   = sum[15:0];
        carry = sum[16];
        flag  = (a[15] == b[15]) && (sum[15] != a[15]);
        // Sign of the untruncated 17-bit signed sum.
        neg   = ((a[15] ^ b[15]) & sum[15]) | (a[15] & b[15]);
      end
      OP_SUB: begin
        c_d  = diff;
        flag = (a[15] != b[15]) && (diff[15] != b[15]);
        neg  = $signed(b) > $signed(a);
        low  = b > a;
      end
`ifdef CR16_ALU_MUL_EN
      // Low half of a product is the same for signed and unsigned operands.
      OP_MUL:  c_d = a * b;
`endif
      OP_NOT:  c_d = ~a;
      OP_AND:  c_d = a & b;
      OP_OR:   c_d = a | b;
      OP_XOR:  c_d = a ^ b;
      OP_LSH, OP_ALSH: c_d = b << shamt;
      OP_RSH:  c_d = b >> shamt;
      OP_ARSH: c_d = 16'($signed(b) >>> shamt);
      default: op_ok = 1'b0;
    endcase
    // Unused opcodes report an all-zero status, including zero.
    status_d = {neg, op_ok & (c_d == 16'd0), flag, low, carry};
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      c_q      <= '0;
      status_q <= '0;
    end else begin
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign bus.O_C      = c_q;
  assign bus.O_STATUS = status_q;
endmodule

// File: tb/tb_cr16_alu.sv
// tb_cr16_alu: self-checking bench for cr16_alu; directed cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_cr16_alu;
  logic I_CLK, I_NRESET;
  cr16_alu_if bus ();

  cr16_alu dut (.I_CLK(I_CLK), .I_NRESET(I_NRESET), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [20:0] model(input logic [3:0] op,
                                        input logic [15:0] a, input logic [15:0] b);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int sh = ua % 16;
    int r = 0;
    int ss = 0;
    logic [4:0]  st = '0;
    logic [15:0] c;
    case (op)
      4'd0, 4'd1: begin
        r  = ua + ub + int'(op);
        ss = sa + sb + int'(op);
        st[0] = r > 65535;
        st[2] = (ss > 32767) || (ss < -32768);
        st[4] = ss < 0;
      end
`ifdef CR16_ALU_MUL_EN
      4'd2: r = sa * sb;
`endif
      4'd3: begin
        r  = ub - ua;
        ss = sb - sa;
        st[2] = (ss > 32767) || (ss < -32768);
        st[4] = sb > sa;
        st[1] = ub > ua;
      end
      4'd4: r = ~ua;
      4'd5: r = ua & ub;
      4'd6: r = ua | ub;
      4'd7: r = ua ^ ub;
      4'd8, 4'd10: r = ub << sh;
      4'd9: r = ub >> sh;
      4'd11: r = sb >>> sh;
      default: return 21'd0;
    endcase
    c = r[15:0];
    st[3] = (c == 16'd0);
    return {st, c};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.I_OPCODE = op;
    bus.I_A      = a;
    bus.I_B      = b;
  endtask

  task automatic test_reset();
    drive(4'd6, 16'h1234, 16'h00F0);
    I_NRESET = 1'b1;
    #1 I_NRESET = 1'b0;
    #1;
    checks++;
    if (bus.O_C !== 16'd0 || bus.O_STATUS !== 5'd0) begin
      errors++;
      $display("FAIL reset_async: C=%h ST=%b want 0000/00000", bus.O_C, bus.O_STATUS);
    end
    repeat (2) @(posedge I_CLK);
    #1;
    checks++;
    if (bus.O_C !== 16'd0 || bus.O_STATUS !== 5'd0) begin
      errors++;
      $display("FAIL reset_hold: C=%h ST=%b want 0000/00000", bus.O_C, bus.O_STATUS);
    end
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    @(negedge I_CLK);
    checks++;
    if (bus.O_C !== 16'h12F4 || bus.O_STATUS !== 5'd0) begin
      errors++;
      $display("FAIL reset_first_capture: C=%h ST=%b want 12f4/00000", bus.O_C, bus.O_STATUS);
    end
  endtask

  // Test-plan vectors with hand-computed expectations.
  task automatic test_directed();
    logic [3:0]  op [11] = '{0, 0, 1, 3, 3, 2, 8, 9, 11, 10, 13};
    logic [15:0] av [11] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h0001, 16'hFFFF,
                             16'hFC00, 16'h0014, 16'h0014, 16'h0014, 16'h0014, 16'hFFFF};
    logic [15:0] bv [11] = '{16'h0001, 16'h8000, 16'h8000, 16'h0003, 16'h0001,
                             16'h0400, 16'h8421, 16'h8421, 16'h8421, 16'h8421, 16'hFFFF};
    logic [15:0] cv [11] = '{16'h8000, 16'h0000, 16'h0001, 16'h0002, 16'h0002,
                             16'h0000, 16'h4210, 16'h0842, 16'hF842, 16'h4210, 16'h0000};
    logic [4:0]  sv [11] = '{5'b00100, 5'b11101, 5'b10101, 5'b10010, 5'b10000,
`ifdef CR16_ALU_MUL_EN
                             5'b01000,
`else
                             5'b00000,
`endif
                             5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    for (int i = 0; i < 11; i++) begin
      @(negedge I_CLK);
      drive(op[i], av[i], bv[i]);
      @(negedge I_CLK);
      checks++;
      if (bus.O_C !== cv[i] || bus.O_STATUS !== sv[i]) begin
        errors++;
        $display("FAIL directed[%0d] op%0d: C=%h ST=%b want %h/%b",
                 i, op[i], bus.O_C, bus.O_STATUS, cv[i], sv[i]);
      end
    end
  endtask

  // New operation every cycle; each result must appear exactly one edge later.
  task automatic test_back_to_back();
    logic [20:0] exp = '0;
    logic [3:0]  op;
    logic [15:0] a, b;
    for (int i = 0; i <= 400; i++) begin
      @(negedge I_CLK);
      if (i > 0) begin
        checks++;
        if ({bus.O_STATUS, bus.O_C} !== exp) begin
          errors++;
          $display("FAIL random[%0d] op%0d a=%h b=%h: C=%h ST=%b want %h/%b",
                   i, op, a, b, bus.O_C, bus.O_STATUS, exp[15:0], exp[20:16]);
        end
      end
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: a = 16'h8000;
        1: b = 16'h7FFF;
        2: a = b;
        3: b = 16'hFFFF;
        default: ;
      endcase
      drive(op, a, b);
      exp = model(op, a, b);
    end
  endtask

  // Input changes between edges must not disturb the held outputs.
  task automatic test_hold();
    logic [20:0] exp;
    @(negedge I_CLK);
    drive(4'd3, 16'h0005, 16'h0100);
    exp = model(4'd3, 16'h0005, 16'h0100);
    @(posedge I_CLK);
    #2 drive(4'd7, 16'hAAAA, 16'h5555);
    #2;
    checks++;
    if ({bus.O_STATUS, bus.O_C} !== exp) begin
      errors++;
      $display("FAIL hold: C=%h ST=%b want %h/%b", bus.O_C, bus.O_STATUS, exp[15:0], exp[20:16]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge I_CLK);
    drive(4'd0, 16'h0001, 16'h0001);
    @(negedge I_CLK);
    checks++;
    if (bus.O_C !== 16'h0002) begin
      errors++;
      $display("FAIL mid_pre: C=%h want 0002", bus.O_C);
    end
    drive(4'd7, 16'h00FF, 16'hF000);
    #2 I_NRESET = 1'b0;
    #1;
    checks++;
    if (bus.O_C !== 16'd0 || bus.O_STATUS !== 5'd0) begin
      errors++;
      $display("FAIL mid_async_clear: C=%h ST=%b want 0000/00000", bus.O_C, bus.O_STATUS);
    end
    @(posedge I_CLK);
    #1;
    checks++;
    if (bus.O_C !== 16'd0 || bus.O_STATUS !== 5'd0) begin
      errors++;
      $display("FAIL mid_held: C=%h ST=%b want 0000/00000", bus.O_C, bus.O_STATUS);
    end
    @(negedge I_CLK);
    I_NRESET = 1'b1;
    #1;
    checks++;
    if (bus.O_C !== 16'd0) begin
      errors++;
      $display("FAIL mid_release_early: C=%h want 0000", bus.O_C);
    end
    @(negedge I_CLK);
    checks++;
    if (bus.O_C !== 16'hF0FF || bus.O_STATUS !== 5'd0) begin
      errors++;
      $display("FAIL mid_first_result: C=%h ST=%b want f0ff/00000", bus.O_C, bus.O_STATUS);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
